// File: rtl/pma_rx_deserializer.sv
// rtl/pma_rx_deserializer.sv - RX PMA deserializer with K28.5 comma alignment
//
// Purpose: rebuilds 10-bit symbols from a serial stream (bit 0 first on the
// wire). Symbol boundaries are found by K28.5 comma detection, and a comma
// found off the current boundary moves the boundary to it.
//
// Ports:
//   Bit_Rate_10  in   bit clock, rising edge
//   Rst          in   asynchronous active-high reset
//   Rx_In        in   serial data
//   Rx_Valid     in   qualifies Rx_In; low holds all state
//   Data_out     out  reconstructed symbol, bit 0 = earliest bit
//   Data_Valid   out  one-cycle strobe, new symbol on Data_out
//   Comma_Det    out  strobed symbol is a K28.5 comma
//   Locked       out  symbol alignment established
//   Realign      out  one-cycle pulse, boundary moved while locked

module pma_rx_deserializer #(
    parameter int                    DATA_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] COMMA_NEG  = 10'h17C,
    parameter logic [DATA_WIDTH-1:0] COMMA_POS  = 10'h283
) (
    input  logic                  Bit_Rate_10,
    input  logic                  Rst,
    input  logic                  Rx_In,
    input  logic                  Rx_Valid,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Data_Valid,
    output logic                  Comma_Det,
    output logic                  Locked,
    output logic                  Realign
);

    localparam logic [3:0] FILL_FULL  = 4'd10;
    localparam logic [3:0] PHASE_LAST = 4'd9;
    localparam logic [3:0] NC_LAST    = 4'd15;

    // One-hot-style encoding; 2'b00 and 2'b11 are illegal and recover to HUNT.
    typedef enum logic [1:0] {
        S_HUNT   = 2'b01,
        S_LOCKED = 2'b10
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [3:0]            r_fill;
    logic [3:0]            r_phase;
    logic [3:0]            r_nc;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dv;
    logic                  r_cd;
    logic                  r_locked;
    logic                  r_rl;

    state_t                w_state_n;
    logic [DATA_WIDTH-1:0] w_sr_n;
    logic [3:0]            w_fill_n;
    logic [3:0]            w_phase_n;
    logic [3:0]            w_nc_n;
    logic [DATA_WIDTH-1:0] w_dout_n;
    logic                  w_dv_n;
    logic                  w_cd_n;
    logic                  w_rl_n;

    logic [DATA_WIDTH-1:0] w_win;
    logic [3:0]            w_fill_inc;
    logic                  w_match;

    // Window as it will look after this cycle's shift.
    assign w_win      = {Rx_In, r_sr[DATA_WIDTH-1:1]};
    assign w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 4'd1;
    assign w_match    = Rx_Valid && (w_fill_inc == FILL_FULL) &&
                        ((w_win == COMMA_NEG) || (w_win == COMMA_POS));

    always_comb begin
        w_state_n = r_state;
        w_sr_n    = r_sr;
        w_fill_n  = r_fill;
        w_phase_n = r_phase;
        w_nc_n    = r_nc;
        w_dout_n  = r_dout;
        w_dv_n    = 1'b0;
        w_cd_n    = 1'b0;
        w_rl_n    = 1'b0;

        if (Rx_Valid) begin
            w_sr_n   = w_win;
            w_fill_n = w_fill_inc;
        end

        case (r_state)
            S_HUNT: begin
                if (w_match) begin
                    w_state_n = S_LOCKED;
                    w_phase_n = 4'd0;
                    w_nc_n    = 4'd0;
                    w_dout_n  = w_win;
                    w_dv_n    = 1'b1;
                    w_cd_n    = 1'b1;
                end
            end
            S_LOCKED: begin
                if (Rx_Valid) begin
                    if (r_phase == PHASE_LAST) begin
                        // Aligned symbol boundary.
                        w_phase_n = 4'd0;
                        w_dout_n  = w_win;
                        w_dv_n    = 1'b1;
                        w_cd_n    = w_match;
                        if (w_match) begin
                            w_nc_n = 4'd0;
                        end else if (r_nc == NC_LAST) begin
                            // 16th comma-free symbol: drop lock, refill window.
                            w_state_n = S_HUNT;
                            w_fill_n  = 4'd0;
                            w_nc_n    = 4'd0;
                        end else begin
                            w_nc_n = r_nc + 4'd1;
                        end
                    end else if (w_match) begin
                        // Comma off the current boundary: restart the symbol here.
                        w_phase_n = 4'd0;
                        w_nc_n    = 4'd0;
                        w_dout_n  = w_win;
                        w_dv_n    = 1'b1;
                        w_cd_n    = 1'b1;
                        w_rl_n    = 1'b1;
                    end else begin
                        w_phase_n = r_phase + 4'd1;
                    end
                end
            end
            default: begin
                w_state_n = S_HUNT;
                w_fill_n  = 4'd0;
                w_phase_n = 4'd0;
                w_nc_n    = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Bit_Rate_10 or posedge Rst) begin
        if (Rst) begin
            r_state  <= S_HUNT;
            r_sr     <= '0;
            r_fill   <= 4'd0;
            r_phase  <= 4'd0;
            r_nc     <= 4'd0;
            r_dout   <= '0;
            r_dv     <= 1'b0;
            r_cd     <= 1'b0;
            r_locked <= 1'b0;
            r_rl     <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_sr     <= w_sr_n;
            r_fill   <= w_fill_n;
            r_phase  <= w_phase_n;
            r_nc     <= w_nc_n;
            r_dout   <= w_dout_n;
            r_dv     <= w_dv_n;
            r_cd     <= w_cd_n;
            r_locked <= (w_state_n == S_LOCKED);
            r_rl     <= w_rl_n;
        end
    end

    assign Data_out   = r_dout;
    assign Data_Valid = r_dv;
    assign Comma_Det  = r_cd;
    assign Locked     = r_locked;
    assign Realign    = r_rl;

endmodule

// File: tb/tb_pma_rx_deserializer.sv
// tb/tb_pma_rx_deserializer.sv - directed-vector bench for pma_rx_deserializer

module tb_pma_rx_deserializer;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic       rx_valid;
    logic [9:0] data_out;
    logic       data_valid;
    logic       comma_det;
    logic       locked;
    logic       realign;

    int n_vec  = 0;
    int n_miss = 0;

    // Strobe capture over one send_sym call.
    int         s_cnt;
    int         s_pos;
    int         s_cyc;
    logic [9:0] s_dout;
    logic       s_cd;
    logic       s_rl;

    pma_rx_deserializer dut (
        .Bit_Rate_10 (clk),
        .Rst         (rst),
        .Rx_In       (rx_in),
        .Rx_Valid    (rx_valid),
        .Data_out    (data_out),
        .Data_Valid  (data_valid),
        .Comma_Det   (comma_det),
        .Locked      (locked),
        .Realign     (realign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_cap();
        s_cnt = 0;
        s_pos = 0;
        s_cyc = 0;
        s_dout = '0;
        s_cd = 1'b0;
        s_rl = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic v);
        rx_in = b;
        rx_valid = v;
        @(posedge clk);
        #1;
        s_cyc++;
        if (data_valid) begin
            s_cnt++;
            s_pos = s_cyc;
            s_dout = data_out;
            s_cd = comma_det;
            s_rl = realign;
        end
    endtask

    // Sends a symbol LSB first; optional Rx_Valid gap after gap_after bits.
    task automatic send_sym(input logic [9:0] v, input int gap_after, input int gap_len);
        logic [9:0] sym;
        sym = v;
        clr_cap();
        for (int i = 0; i < 10; i++) begin
            send_bit(sym[i], 1'b1);
            if (i == gap_after - 1) begin
                for (int g = 0; g < gap_len; g++) send_bit(1'b0, 1'b0);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int tot;
        logic lk15;

        rst = 1'b1;
        rx_in = 1'b0;
        rx_valid = 1'b1;

        // Reset with valid random traffic.
        for (int i = 0; i < 3; i++) begin
            rx_in = 1'($urandom);
            @(posedge clk);
            #1;
        end
        chk_vec("rst_dout",   data_out,   10'h000);
        chk_vec("rst_dv",     data_valid, 0);
        chk_vec("rst_cd",     comma_det,  0);
        chk_vec("rst_locked", locked,     0);
        chk_vec("rst_rl",     realign,    0);
        rst = 1'b0;
        clr_cap();
        for (int i = 0; i < 9; i++) send_bit(1'($urandom), 1'b1);
        chk_vec("rst_9bits_no_strobe", s_cnt, 0);
        chk_vec("rst_9bits_unlocked", locked, 0);

        // Lock on aligned comma.
        do_reset();
        send_sym(10'h17C, 0, 0);
        chk_vec("lock_cnt",    s_cnt,  1);
        chk_vec("lock_pos",    s_pos,  10);
        chk_vec("lock_dout",   s_dout, 10'h17C);
        chk_vec("lock_cd",     s_cd,   1);
        chk_vec("lock_rl",     s_rl,   0);
        chk_vec("lock_locked", locked, 1);
        send_sym(10'h2AA, 0, 0);
        chk_vec("lock2_cnt",  s_cnt,  1);
        chk_vec("lock2_pos",  s_pos,  10);
        chk_vec("lock2_dout", s_dout, 10'h2AA);
        chk_vec("lock2_cd",   s_cd,   0);

        // Offset lock after three stray bits.
        do_reset();
        clr_cap();
        for (int i = 0; i < 3; i++) send_bit(1'($urandom), 1'b1);
        chk_vec("off_pre_cnt", s_cnt, 0);
        send_sym(10'h283, 0, 0);
        chk_vec("off283_cnt",    s_cnt,  1);
        chk_vec("off283_pos",    s_pos,  10);
        chk_vec("off283_dout",   s_dout, 10'h283);
        chk_vec("off283_cd",     s_cd,   1);
        chk_vec("off283_locked", locked, 1);
        send_sym(10'h155, 0, 0);
        chk_vec("off155_cnt",  s_cnt,  1);
        chk_vec("off155_pos",  s_pos,  10);
        chk_vec("off155_dout", s_dout, 10'h155);
        chk_vec("off155_cd",   s_cd,   0);
        chk_vec("off155_rl",   s_rl,   0);
        send_sym(10'h17C, 0, 0);
        chk_vec("off17c_cnt",  s_cnt,  1);
        chk_vec("off17c_pos",  s_pos,  10);
        chk_vec("off17c_dout", s_dout, 10'h17C);
        chk_vec("off17c_cd",   s_cd,   1);
        chk_vec("off17c_rl",   s_rl,   0);

        // Four-cycle Rx_Valid gap mid-symbol.
        send_sym(10'h3F0, 5, 4);
        chk_vec("gap_cnt",  s_cnt,  1);
        chk_vec("gap_pos",  s_pos,  14);
        chk_vec("gap_dout", s_dout, 10'h3F0);
        chk_vec("gap_cd",   s_cd,   0);

        // Five extra bits then a comma: one aligned junk symbol, then realign.
        clr_cap();
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        chk_vec("ra_extra_cnt", s_cnt, 0);
        send_sym(10'h17C, 0, 0);
        chk_vec("ra_cnt",    s_cnt,  2);
        chk_vec("ra_pos",    s_pos,  10);
        chk_vec("ra_dout",   s_dout, 10'h17C);
        chk_vec("ra_cd",     s_cd,   1);
        chk_vec("ra_rl",     s_rl,   1);
        chk_vec("ra_locked", locked, 1);

        // Sixteen comma-free symbols drop lock on the 16th.
        tot = 0;
        lk15 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            send_sym(10'h2AA, 0, 0);
            tot += s_cnt;
            if (k == 15) lk15 = locked;
        end
        chk_vec("loss_total",   tot,    16);
        chk_vec("loss_lk15",    lk15,   1);
        chk_vec("loss_locked",  locked, 0);
        chk_vec("loss_dout",    s_dout, 10'h2AA);
        chk_vec("loss_cd",      s_cd,   0);
        tot = 0;
        for (int k = 0; k < 2; k++) begin
            send_sym(10'h2AA, 0, 0);
            tot += s_cnt;
        end
        chk_vec("hunt_no_strobe", tot,      0);
        chk_vec("hunt_hold_dout", data_out, 10'h2AA);
        chk_vec("hunt_locked",    locked,   0);
        send_sym(10'h17C, 0, 0);
        chk_vec("relock_cnt",    s_cnt,  1);
        chk_vec("relock_dout",   s_dout, 10'h17C);
        chk_vec("relock_locked", locked, 1);

        // Asynchronous reset mid-symbol.
        clr_cap();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_vec("arst_locked", locked,   0);
        chk_vec("arst_dout",   data_out, 10'h000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pma_rx_deserializer.md
# pma_rx_deserializer

Receive-side PMA stage that consumes the serial bit stream produced by the TX PMA serializer, one bit per clock. It finds symbol boundaries using 8b/10b K28.5 comma detection, then rebuilds 10-bit symbols in the same bit order the serializer uses (Data_in[0] is the first bit on the wire). Each reconstructed symbol is handed to the downstream 8b/10b decoder with a one-cycle valid strobe.

## Interface
- DATA_WIDTH, 10: symbol width in bits; only 10 is supported.
- COMMA_NEG, 10'h17C: K28.5 RD− in parallel-bus bit order (bit 0 sent first).
- COMMA_POS, 10'h283: K28.5 RD+ in parallel-bus bit order.
- Bit_Rate_10  in  1  bit clock; all logic on its rising edge.
- Rst  in  1  reset; asynchronous, active-high.
- Rx_In  in  1  serial data; connects to TX_Out in loopback.
- Rx_Valid  in  1  qualifies Rx_In; connects to TX_Done in loopback.
- Data_out  out  DATA_WIDTH  reconstructed symbol; bit 0 is the earliest received bit.
- Data_Valid  out  1  one-cycle strobe; Data_out holds a new symbol.
- Comma_Det  out  1  asserted with Data_Valid when Data_out is COMMA_NEG or COMMA_POS.
- Locked  out  1  level; symbol alignment is established.
- Realign  out  1  one-cycle pulse; a misaligned comma moved the boundary while locked.

## Operation
- Shift window sr[9:0], updated only on cycles with Rx_Valid=1: sr <= {Rx_In, sr[9:1]}.
- Define win as the value sr takes after this cycle's shift. After 10 valid bits, win[0] is the oldest bit.
- With Rx_Valid=0 the block holds everything: no shift, no count, no output strobe.
- fill counter (0..10, saturating) counts valid bits since reset or since the last lock loss. Comma matching is enabled only when fill has reached 10 after this cycle's shift.
- phase counter (0..9) tracks the bit position inside the current symbol while LOCKED.
- State HUNT (reset state):
  - Locked=0.
  - If win matches either comma: go to LOCKED, phase <= 0, Data_out <= win, Data_Valid=1, Comma_Det=1.
  - Otherwise stay in HUNT with no output.
- State LOCKED:
  - Locked=1.
  - Each valid bit advances phase (mod 10).
  - When phase==9 on a valid bit, the symbol is complete: Data_out <= win, Data_Valid=1, Comma_Det = (win is a comma), phase <= 0.
- Misaligned comma while LOCKED: win matches a comma while phase!=9. The boundary moves to this bit: Data_out <= win, Data_Valid=1, Comma_Det=1, Realign=1, phase <= 0. The partial symbol already in progress is discarded.
- Loss of lock: 16 consecutive aligned symbols with no comma send the block to HUNT and clear fill to 0. Commas arriving through a Realign event also reset this count.
- The comparator checks only the two exact comma codes; no running-disparity or code-validity checking is done here.
- Undefined state encoding recovers to HUNT.

## Timing
- Reset (asynchronous, on Rst high): state=HUNT, sr=0, fill=0, phase=0, no-comma count=0. All outputs read 0: Data_out=0, Data_Valid=0, Comma_Det=0, Locked=0, Realign=0.
- All outputs are registered.
- Latency: Data_Valid, Comma_Det and Realign rise on the same edge that samples the 10th bit of a symbol and last exactly one cycle.
- Locked rises on the edge that detects the first comma. It falls on the edge of the 16th comma-free aligned symbol; that symbol is still output with Data_Valid=1.
- Data_out holds its value between strobes.
- Rx_Valid low mid-symbol stretches the symbol with no data loss. Strobes occur only on cycles with Rx_Valid=1.
- Rst asserted mid-symbol discards the partial symbol. After release, at least 10 valid bits must arrive before the first possible strobe.
- Back-to-back symbols (Rx_Valid held high) produce one Data_Valid every 10 cycles.

## Test plan
- Reset check: assert Rst with Rx_Valid=1 and random Rx_In -> all outputs 0. After release, no strobe within the first 9 valid bits.
- Lock: send 10'h17C LSB-first, then 10'h2AA -> first strobe with Data_out=10'h17C, Comma_Det=1, Locked=1. Ten cycles later a strobe with Data_out=10'h2AA, Comma_Det=0.
- Offset lock: send 3 random bits, then 10'h283, 10'h155, 10'h17C -> first strobe is 10'h283, followed by 10'h155 and 10'h17C at 10-cycle spacing, with no Realign.
- Gaps: while locked, drop Rx_Valid for 4 cycles in the middle of 10'h3F0 -> one strobe with Data_out=10'h3F0, delayed by 4 cycles.
- Realign: while locked, insert 5 extra bits, then 10'h17C -> strobe with Data_out=10'h17C, Comma_Det=1, Realign=1, Locked stays 1.
- Lock loss: after lock, send 16 symbols of 10'h2AA -> 16 strobes, Locked=0 on the 16th, then no strobes until the next comma.
